// File: rtl/inst_prefetch_if.sv
// Fetch-side and instruction-memory signals of the prefetch buffer.
// The prefetcher is the master: it drives the memory reads and the fetch-stage outputs.
interface inst_prefetch_if;
    logic        i_redirect;
    logic [15:0] i_redirect_addr;
    logic [15:0] o_inst;
    logic [15:0] o_inst_pc;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [15:0] o_imem_addr;
    logic        o_imem_rd;
    logic        i_imem_waitrequest;
    logic [15:0] i_imem_rddata;
    logic        i_imem_rddatavalid;

    modport master (
        input  i_redirect, i_redirect_addr, i_inst_ready,
               i_imem_waitrequest, i_imem_rddata, i_imem_rddatavalid,
        output o_inst, o_inst_pc, o_inst_valid, o_imem_addr, o_imem_rd
    );

    modport slave (
        output i_redirect, i_redirect_addr, i_inst_ready,
               i_imem_waitrequest, i_imem_rddata, i_imem_rddatavalid,
        input  o_inst, o_inst_pc, o_inst_valid, o_imem_addr, o_imem_rd
    );
endinterface

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher: credit-limited pipelined reads into a show-ahead FIFO,
// with redirect flushing the buffer and discarding responses that were already in flight.
module inst_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic           clk,
    input  logic           reset,
    inst_prefetch_if.master bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CRW = CW + 2;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d, live_q, live_d, disc_q, disc_d;
    logic [15:0]        fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, addr_q, addr_d;
    logic               rd_q, rd_d, stale_q, stale_d;

    logic               redir, accept, held, push, pop, inst_valid;
    logic [15:0]        redir_pc;
    logic [CRW-1:0]     credit;

    assign inst_valid = (cnt_q != '0);

    always_comb begin
        redir    = bus.i_redirect;
        redir_pc = {bus.i_redirect_addr[15:1], 1'b0};
        accept   = rd_q & ~bus.i_imem_waitrequest;
        held     = rd_q &  bus.i_imem_waitrequest;
        push     = bus.i_imem_rddatavalid & (disc_q == '0) & ~redir;
        pop      = inst_valid & bus.i_inst_ready;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        resp_pc_d  = resp_pc_q;
        fetch_pc_d = fetch_pc_q;

        if (push) begin
            mem_d[wr_ptr_q].inst = bus.i_imem_rddata;
            mem_d[wr_ptr_q].pc   = resp_pc_q;
            wr_ptr_d  = wr_ptr_q + 1'b1;
            resp_pc_d = resp_pc_q + 16'd2;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;

        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        live_d = live_q + CW'(accept & ~stale_q) - CW'(push);
        // A stale request is one that was held by waitrequest when a redirect hit.
        disc_d = disc_q + CW'(accept & stale_q)
                 - CW'(bus.i_imem_rddatavalid & (disc_q != '0));
        stale_d = stale_q & ~accept;
        if (accept & ~stale_q)
            fetch_pc_d = fetch_pc_q + 16'd2;

        if (redir) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            live_d     = '0;
            fetch_pc_d = redir_pc;
            resp_pc_d  = redir_pc;
            // Every read still owed by memory becomes a discard; a response this cycle settles one.
            disc_d     = disc_q + live_q + CW'(accept) - CW'(bus.i_imem_rddatavalid);
            stale_d    = held;
        end

        credit = CRW'(cnt_d) + CRW'(live_d) + CRW'(disc_d);
        if (held) begin
            rd_d   = 1'b1;
            addr_d = addr_q;
        end else begin
            rd_d   = (credit < CRW'(DEPTH)) & ~(redir & ~rd_q);
            addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            live_q     <= '0;
            disc_q     <= '0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            addr_q     <= RESET_PC;
            rd_q       <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            live_q     <= live_d;
            disc_q     <= disc_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            stale_q    <= stale_d;
        end
    end

    assign bus.o_inst       = mem_q[rd_ptr_q].inst;
    assign bus.o_inst_pc    = mem_q[rd_ptr_q].pc;
    assign bus.o_inst_valid = inst_valid;
    assign bus.o_imem_rd    = rd_q;
    assign bus.o_imem_addr  = addr_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && cnt_q == CW'(DEPTH)));
endmodule

// File: doc/inst_prefetch.md
Name: inst_prefetch

Overview:
- Instruction prefetch buffer between the instruction memory and the CPU fetch stage.
- Issues sequential 16-bit instruction reads (PC += 2) on an Avalon-MM pipelined read port with waitrequest and readdatavalid.
- Buffers returned words with their PCs in a FIFO and presents them to the fetch stage over a valid/ready handshake.
- A redirect (taken branch or jump) flushes the buffer, discards in-flight responses, and restarts fetch at the new address.

Parameters:
DEPTH, 4, FIFO entries and maximum reads outstanding; power of 2, minimum 2
RESET_PC, 16'h0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
i_redirect  input  1  flush and restart fetch at i_redirect_addr
i_redirect_addr  input  16  new fetch address; bit 0 ignored (forced 0)
o_inst  output  16  instruction at FIFO head
o_inst_pc  output  16  PC of o_inst
o_inst_valid  output  1  FIFO head valid
i_inst_ready  input  1  consumer accepts the head this cycle
o_imem_addr  output  16  read address
o_imem_rd  output  1  read request
i_imem_waitrequest  input  1  request not accepted this cycle
i_imem_rddata  input  16  read data
i_imem_rddatavalid  input  1  read data valid; responses return in request order

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty; live_cnt=0; discard_cnt=0.
  - o_imem_rd=0, o_imem_addr=RESET_PC, o_inst_valid=0.
  - o_inst and o_inst_pc show FIFO head storage, which reads 0 after reset.
- Request side:
  - o_imem_rd and o_imem_addr are registered.
  - A request is accepted in a cycle where o_imem_rd=1 and i_imem_waitrequest=0.
  - While o_imem_rd=1 and waitrequest=1, the request holds: rd, addr and the request itself stay stable, including across a redirect.
- Issue rule:
  - At each edge, o_imem_rd is 1 on the next cycle when fifo_count + live_cnt + accepted_or_pending < DEPTH, and no redirect occurred this cycle while idle.
  - Otherwise o_imem_rd is 0.
  - On acceptance, fetch_pc += 2 (wraps 16'hFFFE -> 16'h0000), and o_imem_addr takes the new fetch_pc if the request continues.
  - Back-to-back acceptance gives 1 read per cycle.
- Response side, on i_imem_rddatavalid=1:
  - If discard_cnt>0: drop the word and decrement discard_cnt.
  - Otherwise: push {i_imem_rddata, resp_pc}, resp_pc += 2, live_cnt -= 1.
  - The FIFO never overflows; the credit rule guarantees space. Assert on violation in simulation.
- live_cnt: +1 on acceptance, -1 on a live response; simultaneous +1/-1 leaves it unchanged.
- Output side:
  - Show-ahead: o_inst, o_inst_pc and o_inst_valid come from the FIFO head combinationally.
  - Pop on o_inst_valid & i_inst_ready.
  - Simultaneous push and pop are allowed, including when full or empty.
  - Empty FIFO with a same-cycle response: o_inst_valid rises on the cycle after the push (no bypass). Minimum latency from request acceptance to o_inst_valid is memory latency + 1 cycle.
- Redirect (i_redirect=1 at an edge), which takes priority over all other updates:
  - FIFO flushed, so o_inst_valid=0 on the next cycle. A pop handshake in the redirect cycle is harmless.
  - fetch_pc and resp_pc load {i_redirect_addr[15:1], 1'b0}.
  - discard_cnt += live_cnt, plus any acceptance this cycle, minus any discarded response this cycle. live_cnt=0.
  - A response arriving in the redirect cycle is discarded.
  - A held (waitrequest) request completes at its old address and is counted into discard_cnt when accepted. Fetch then resumes at the new fetch_pc.
  - Back-to-back redirects: the last one wins, and discard counts accumulate.
  - New fetches are issued while discards are still outstanding, provided credit allows. Discards always count against credit.
- Counter widths: fifo_count, live_cnt and discard_cnt are each clog2(DEPTH)+1 bits. discard_cnt <= DEPTH by construction.

Test Plan:
1. Reset release, zero-wait memory (1-cycle latency), ready=1 -> addresses 0,2,4,… issued one per cycle; o_inst_pc sequence 0,2,4,… with matching data; steady throughput 1 instruction per cycle.
2. ready=0 held, DEPTH=4 -> exactly 4 reads accepted, o_imem_rd drops; FIFO holds PCs 0,2,4,6. Ready=1 for one cycle -> one pop, one new read at addr 8.
3. Memory latency 3 cycles with 2 reads in flight; redirect to 16'h0041 -> next-cycle valid=0; both old responses dropped; next delivered o_inst_pc=16'h0040 with data from 0x40.
4. waitrequest=1 held 5 cycles on addr 0x10, redirect to 0x80 mid-stall -> addr 0x10 held until accepted; its response discarded; next request at 0x80.
5. Redirect asserted on 2 consecutive cycles (0x20, then 0x30) with responses in flight -> no stale word delivered; first delivered pc=0x30.
6. reset asserted mid-burst with reads in flight -> outputs immediately o_imem_rd=0, o_inst_valid=0. After release, first request at RESET_PC; stale responses arriving before new issue are ignored by the bench memory model.
